// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer.
//
// Looks up the fetch PC and returns a registered hit/target/direction
// prediction one cycle later. Trained with resolved branch outcomes.
// Each entry holds a saturating direction counter. Each set keeps
// per-way LRU ages, where age 0 is the most recently used way.
// A sequenced flush engine clears the valid bits one set per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fetch_valid       pc_in carries a valid lookup this cycle
//   pc_in             fetch PC
//   pred_valid        registered: lookup hit
//   pred_target       registered: stored target on hit, else 0
//   pred_taken        registered: counter MSB on hit, else 0
//   update_req        training request
//   update_pc         PC of the resolved branch
//   update_target     resolved target
//   update_taken      resolved direction
//   flush_req         single-cycle pulse that invalidates every entry
//   busy              flush in progress
module btb_assoc #(
  parameter int SETS     = 16,
  parameter int WAYS     = 2,
  parameter int PC_W     = 32,
  parameter int CNT_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid,
  input  logic [PC_W-1:0] pc_in,
  output logic            pred_valid,
  output logic [PC_W-1:0] pred_target,
  output logic            pred_taken,
  input  logic            update_req,
  input  logic [PC_W-1:0] update_pc,
  input  logic [PC_W-1:0] update_target,
  input  logic            update_taken,
  input  logic            flush_req,
  output logic            busy
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = PC_W - INDEX_BITS - 2;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1 << (CNT_BITS - 1));

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   ptr_q, ptr_d;

  logic                    valid_q  [SETS][WAYS];
  logic [TAG_BITS-1:0]     tag_q    [SETS][WAYS];
  logic [PC_W-1:0]         target_q [SETS][WAYS];
  logic [CNT_BITS-1:0]     cnt_q    [SETS][WAYS];
  logic [WAY_W-1:0]        age_q    [SETS][WAYS];

  logic                    pred_valid_q, pred_valid_d;
  logic [PC_W-1:0]         pred_target_q, pred_target_d;
  logic                    pred_taken_q, pred_taken_d;

  logic [INDEX_BITS-1:0]   lk_idx, up_idx;
  logic [TAG_BITS-1:0]     lk_tag, up_tag;
  logic                    lk_hit, up_hit;
  logic [WAY_W-1:0]        lk_way, up_way, victim, sel_way;
  logic                    found_free;
  logic                    blocked, up_en, do_write;
  logic [CNT_BITS-1:0]     cnt_cur, cnt_new;
  logic [WAY_W-1:0]        age_ref;
  logic [WAY_W-1:0]        age_new [WAYS];

  // The two low PC bits never select anything (word-aligned branches).
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_in[1:0], update_pc[1:0]};

  assign lk_idx = pc_in[INDEX_BITS+1:2];
  assign lk_tag = pc_in[PC_W-1:INDEX_BITS+2];
  assign up_idx = update_pc[INDEX_BITS+1:2];
  assign up_tag = update_pc[PC_W-1:INDEX_BITS+2];

  assign busy = (state_q == FLUSH);
  // A flush request accepted this cycle already blocks lookups and updates.
  assign blocked = busy || flush_req;

  // Tag compare for the lookup and the update ports.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    up_hit = 1'b0;
    up_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
    end
  end

  // Registered prediction; the lookup reads pre-update contents.
  always_comb begin
    pred_valid_d  = fetch_valid && lk_hit && !blocked;
    pred_target_d = '0;
    pred_taken_d  = 1'b0;
    if (pred_valid_d) begin
      pred_target_d = target_q[lk_idx][lk_way];
      pred_taken_d  = cnt_q[lk_idx][lk_way][CNT_BITS-1];
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the oldest way.
  always_comb begin
    found_free = 1'b0;
    victim     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !valid_q[up_idx][w]) begin
        found_free = 1'b1;
        victim     = WAY_W'(w);
      end
    end
    if (!found_free) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[up_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  // Update datapath: saturating counter and LRU touch of the written way.
  always_comb begin
    up_en    = update_req && !blocked;
    do_write = up_en && (up_hit || update_taken);
    sel_way  = up_hit ? up_way : victim;
    cnt_cur  = cnt_q[up_idx][up_way];
    cnt_new  = cnt_cur;
    if (update_taken) begin
      if (cnt_cur != CNT_MAX) cnt_new = cnt_cur + CNT_BITS'(1);
    end else if (cnt_cur != '0) begin
      cnt_new = cnt_cur - CNT_BITS'(1);
    end
    age_ref = age_q[up_idx][sel_way];
    for (int w = 0; w < WAYS; w++) begin
      age_new[w] = age_q[up_idx][w];
      if (WAY_W'(w) == sel_way) age_new[w] = '0;
      else if (age_q[up_idx][w] < age_ref) age_new[w] = age_q[up_idx][w] + WAY_W'(1);
    end
  end

  // Flush sequencer: walks the pointer across every set once.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          ptr_d   = '0;
        end
      end
      FLUSH: begin
        ptr_d = ptr_q + INDEX_BITS'(1);
        if (ptr_q == INDEX_BITS'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      pred_valid_q  <= 1'b0;
      pred_target_q <= '0;
      pred_taken_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          cnt_q[s][w]    <= '0;
          age_q[s][w]    <= WAY_W'(w);
        end
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      pred_valid_q  <= pred_valid_d;
      pred_target_q <= pred_target_d;
      pred_taken_q  <= pred_taken_d;
      if (state_q == FLUSH) begin
        for (int w = 0; w < WAYS; w++) valid_q[ptr_q][w] <= 1'b0;
      end
      if (do_write) begin
        valid_q[up_idx][sel_way] <= 1'b1;
        tag_q[up_idx][sel_way]   <= up_tag;
        cnt_q[up_idx][sel_way]   <= up_hit ? cnt_new : CNT_INIT;
        if (update_taken) target_q[up_idx][sel_way] <= update_target;
        for (int w = 0; w < WAYS; w++) age_q[up_idx][w] <= age_new[w];
      end
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_target = pred_target_q;
  assign pred_taken  = pred_taken_q;

endmodule
